// File: rtl/rr_priority_arbiter_8_if.sv
// Request/grant bundle between 8 requesters and the round-robin arbiter.
// master = requester side, slave = arbiter side.
interface rr_priority_arbiter_8_if;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;

  modport master (
    output req,
    input  gnt, gnt_id, gnt_valid, timeout
  );

  modport slave (
    input  req,
    output gnt, gnt_id, gnt_valid, timeout
  );
endinterface

// File: rtl/rr_priority_arbiter_8.sv
// 8-way round-robin arbiter, descending search from ptr, with bounded hold.
// Registered one-hot grant, owner index, valid flag and timeout pulse.
module rr_priority_arbiter_8 #(
  parameter int MAX_HOLD = 16,
  parameter int HOLD_W   = 5
) (
  input logic                   clk,
  input logic                   rst_n,
  rr_priority_arbiter_8_if.slave bus
);

  typedef enum logic {IDLE, OWN} state_t;

  state_t            state, state_n;
  logic [2:0]        ptr, ptr_n;
  logic [HOLD_W-1:0] cnt, cnt_n;
  logic [7:0]        gnt, gnt_n;
  logic [2:0]        id, id_n;
  logic              to, to_n;
  logic [2:0]        win, idx;
  logic              found;

  // First set request walking down from ptr, wrapping 0 -> 7.
  always_comb begin
    win   = ptr;
    found = 1'b0;
    idx   = ptr;
    for (int k = 0; k < 8; k++) begin
      idx = ptr - 3'(k);
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    cnt_n   = cnt;
    gnt_n   = gnt;
    id_n    = id;
    to_n    = 1'b0;
    unique case (state)
      IDLE: begin
        gnt_n = '0;
        if (found) begin
          gnt_n   = 8'(1) << win;
          id_n    = win;
          cnt_n   = HOLD_W'(1);
          state_n = OWN;
        end
      end
      OWN: begin
        if (!bus.req[id]) begin
          gnt_n   = '0;
          ptr_n   = id - 3'd1;
          cnt_n   = '0;
          state_n = IDLE;
        end else if (cnt == HOLD_W'(MAX_HOLD)) begin
          gnt_n   = '0;
          to_n    = 1'b1;
          ptr_n   = id - 3'd1;
          cnt_n   = '0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + HOLD_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= 3'd7;
      cnt   <= '0;
      gnt   <= '0;
      id    <= '0;
      to    <= 1'b0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      cnt   <= cnt_n;
      gnt   <= gnt_n;
      id    <= id_n;
      to    <= to_n;
    end
  end

  assign bus.gnt       = gnt;
  assign bus.gnt_id    = id;
  assign bus.gnt_valid = |gnt;
  assign bus.timeout   = to;

endmodule

// File: tb/tb_rr_priority_arbiter_8.sv
// Randomized and directed bench for rr_priority_arbiter_8.
// Reference model tracks owner/pointer/hold count as plain integers.
module tb_rr_priority_arbiter_8;

  localparam int MAX_HOLD = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  rr_priority_arbiter_8_if bus ();

  rr_priority_arbiter_8 #(
    .MAX_HOLD(MAX_HOLD),
    .HOLD_W  (5)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  int         m_own;
  int         m_ptr;
  int         m_cnt;
  logic [7:0] e_gnt;
  logic [2:0] e_id;
  logic       e_to;
  int         run;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_own = -1;
    m_ptr = 7;
    m_cnt = 0;
    e_gnt = '0;
    e_id  = '0;
    e_to  = 1'b0;
    run   = 0;
  endtask

  task automatic model_edge(input logic [7:0] r);
    e_to = 1'b0;
    if (m_own < 0) begin
      for (int k = 0; k < 8; k++) begin
        int c;
        c = (m_ptr - k + 8) % 8;
        if (m_own < 0 && r[c]) begin
          m_own = c;
          m_cnt = 1;
        end
      end
    end else if (!r[m_own]) begin
      m_ptr = (m_own + 7) % 8;
      m_own = -1;
    end else if (m_cnt == MAX_HOLD) begin
      e_to  = 1'b1;
      m_ptr = (m_own + 7) % 8;
      m_own = -1;
    end else begin
      m_cnt++;
    end
    e_gnt = (m_own < 0) ? 8'h00 : (8'h01 << m_own);
    if (m_own >= 0) e_id = 3'(m_own);
  endtask

  task automatic step(input logic [7:0] r);
    bus.req = r;
    @(posedge clk);
    model_edge(r);
    #1;
    chk("gnt", {24'h0, bus.gnt}, {24'h0, e_gnt});
    chk("gnt_valid", {31'h0, bus.gnt_valid}, {31'h0, (e_gnt != 0)});
    chk("timeout", {31'h0, bus.timeout}, {31'h0, e_to});
    if (e_gnt != 0) chk("gnt_id", {29'h0, bus.gnt_id}, {29'h0, e_id});
    chk("onehot0", {31'h0, $onehot0(bus.gnt)}, 32'h1);
    run = (bus.gnt != 0) ? run + 1 : 0;
    chk("hold_max", {31'h0, (run <= MAX_HOLD)}, 32'h1);
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    bus.req = 8'hFF;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", {24'h0, bus.gnt}, 32'h0);
    chk("rst_valid", {31'h0, bus.gnt_valid}, 32'h0);
    chk("rst_timeout", {31'h0, bus.timeout}, 32'h0);
    model_reset();
    @(negedge clk);
    rst_n   = 1'b1;
    bus.req = 8'h00;
  endtask

  initial begin
    logic [7:0] r;
    bus.req = 8'h00;
    model_reset();
    do_reset();

    // single requester
    step(8'h10);
    chk("single_gnt", {24'h0, bus.gnt}, 32'h10);
    chk("single_id", {29'h0, bus.gnt_id}, 32'h4);
    step(8'h10);
    step(8'h10);
    step(8'h00);
    chk("single_rel", {24'h0, bus.gnt}, 32'h0);

    // async reset mid-grant
    step(8'h02);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst", {24'h0, bus.gnt}, 32'h0);
    chk("async_to", {31'h0, bus.timeout}, 32'h0);
    do_reset();

    // rotation with all requesting, 2-cycle tenures
    for (int i = 0; i < 9; i++) begin
      int w;
      w = (7 - i + 8) % 8;
      step(8'hFF);
      chk("rot_gnt", {24'h0, bus.gnt}, 32'h1 << w);
      step(8'hFF);
      r = 8'hFF;
      r[w] = 1'b0;
      step(r);
      chk("rot_idle", {24'h0, bus.gnt}, 32'h0);
    end

    // owner 3 releases, ptr=2 -> 4 beats 3
    do_reset();
    step(8'h08);
    chk("prio_own3", {24'h0, bus.gnt}, 32'h08);
    step(8'h10);
    step(8'h18);
    chk("prio_gnt4", {24'h0, bus.gnt}, 32'h10);
    step(8'h00);

    // timeout with sole requester
    do_reset();
    step(8'h01);
    for (int i = 1; i < MAX_HOLD; i++) step(8'h01);
    chk("to_held", {24'h0, bus.gnt}, 32'h01);
    step(8'h01);
    chk("to_gnt0", {24'h0, bus.gnt}, 32'h0);
    chk("to_pulse", {31'h0, bus.timeout}, 32'h1);
    step(8'h01);
    chk("to_regnt", {24'h0, bus.gnt}, 32'h01);
    chk("to_clear", {31'h0, bus.timeout}, 32'h0);

    // drop on the final hold cycle: plain release
    do_reset();
    step(8'h01);
    for (int i = 1; i < MAX_HOLD; i++) step(8'h01);
    step(8'h00);
    chk("sim_gnt0", {24'h0, bus.gnt}, 32'h0);
    chk("sim_noto", {31'h0, bus.timeout}, 32'h0);

    // random traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      r = 8'($urandom);
      if ($urandom_range(0, 7) == 0) r = 8'h00;
      if (m_own >= 0 && $urandom_range(0, 9) < 8) r[m_own] = 1'b1;
      step(r);
    end
    step(8'h00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
